// File: rtl/ist_dispatch.sv
// rtl/ist_dispatch.sv - Ray/triangle-range sequencer that feeds the ist intersection unit
//
// Purpose: accepts one ray plus a contiguous triangle index range, fetches each
// triangle word from the triangle buffer, issues it to ist, and narrows the
// active tmax after every accepted hit. When the range is exhausted it pulses
// hit_valid with the closest hit (t, u, v, triangle index).
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   ray_valid / ray_ready       ray handshake (ready only while idle)
//   origin_*, dir_*, tmax       ray fields, sampled on accept
//   tri_first, tri_count        triangle range (count may be zero)
//   tri_req / tri_addr          one-cycle read request, address held until tri_rvalid
//   tri_rvalid / tri_rdata      read response (384-bit triangle word)
//   ist_valid, ist_*            start pulse and registered operands to ist
//   ist_done, ist_intersected,
//   ist_t, ist_u, ist_v         ist completion and results
//   hit_valid, hit, hit_t,
//   hit_u, hit_v, hit_index     closest-hit report
//   busy                        high whenever a ray is in flight
//
// Build option: IST_DISPATCH_PREFETCH_EN adds a second triangle buffer and
// fetches triangle idx+1 while ist is working on triangle idx.

module ist_dispatch #(
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ray_valid,
  output logic             ray_ready,
  input  logic [31:0]      origin_x,
  input  logic [31:0]      origin_y,
  input  logic [31:0]      origin_z,
  input  logic [31:0]      dir_x,
  input  logic [31:0]      dir_y,
  input  logic [31:0]      dir_z,
  input  logic [31:0]      tmax,
  input  logic [IDX_W-1:0] tri_first,
  input  logic [IDX_W:0]   tri_count,
  output logic             tri_req,
  output logic [IDX_W-1:0] tri_addr,
  input  logic             tri_rvalid,
  input  logic [383:0]     tri_rdata,
  output logic             ist_valid,
  output logic [31:0]      ist_origin_x,
  output logic [31:0]      ist_origin_y,
  output logic [31:0]      ist_origin_z,
  output logic [31:0]      ist_dir_x,
  output logic [31:0]      ist_dir_y,
  output logic [31:0]      ist_dir_z,
  output logic [31:0]      ist_tmax,
  output logic [31:0]      ist_p0_x,
  output logic [31:0]      ist_p0_y,
  output logic [31:0]      ist_p0_z,
  output logic [31:0]      ist_e1_x,
  output logic [31:0]      ist_e1_y,
  output logic [31:0]      ist_e1_z,
  output logic [31:0]      ist_e2_x,
  output logic [31:0]      ist_e2_y,
  output logic [31:0]      ist_e2_z,
  output logic [31:0]      ist_n_x,
  output logic [31:0]      ist_n_y,
  output logic [31:0]      ist_n_z,
  input  logic             ist_done,
  input  logic             ist_intersected,
  input  logic [31:0]      ist_t,
  input  logic [31:0]      ist_u,
  input  logic [31:0]      ist_v,
  output logic             hit_valid,
  output logic             hit,
  output logic [31:0]      hit_t,
  output logic [31:0]      hit_u,
  output logic [31:0]      hit_v,
  output logic [IDX_W-1:0] hit_index,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_MEM, S_ISSUE, S_WAIT_IST, S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W:0]   REM_ONE = {{IDX_W{1'b0}}, 1'b1};

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W:0]   remaining;
  // Operand buffer for the triangle currently owned by ist; it only changes
  // outside the ist_valid..ist_done window.
  logic [383:0]     tri_buf;
`ifdef IST_DISPATCH_PREFETCH_EN
  logic [383:0]     pf_buf;
  logic             pf_have;  // prefetched word parked in pf_buf
  logic             pf_pend;  // prefetch read outstanding
`endif

  assign ist_p0_x = tri_buf[31:0];
  assign ist_p0_y = tri_buf[63:32];
  assign ist_p0_z = tri_buf[95:64];
  assign ist_e1_x = tri_buf[127:96];
  assign ist_e1_y = tri_buf[159:128];
  assign ist_e1_z = tri_buf[191:160];
  assign ist_e2_x = tri_buf[223:192];
  assign ist_e2_y = tri_buf[255:224];
  assign ist_e2_z = tri_buf[287:256];
  assign ist_n_x  = tri_buf[319:288];
  assign ist_n_y  = tri_buf[351:320];
  assign ist_n_z  = tri_buf[383:352];

  // ist_tmax doubles as the running cur_tmax: ist rejects t >= tmax, so every
  // reported hit is strictly closer than the previous one and the first-issued
  // triangle wins among equal t without any float compare here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      ray_ready    <= 1'b1;
      busy         <= 1'b0;
      idx          <= '0;
      remaining    <= '0;
      tri_buf      <= '0;
      tri_req      <= 1'b0;
      tri_addr     <= '0;
      ist_valid    <= 1'b0;
      ist_origin_x <= '0;
      ist_origin_y <= '0;
      ist_origin_z <= '0;
      ist_dir_x    <= '0;
      ist_dir_y    <= '0;
      ist_dir_z    <= '0;
      ist_tmax     <= '0;
      hit_valid    <= 1'b0;
      hit          <= 1'b0;
      hit_t        <= '0;
      hit_u        <= '0;
      hit_v        <= '0;
      hit_index    <= '0;
`ifdef IST_DISPATCH_PREFETCH_EN
      pf_buf       <= '0;
      pf_have      <= 1'b0;
      pf_pend      <= 1'b0;
`endif
    end else begin
      tri_req   <= 1'b0;
      ist_valid <= 1'b0;
      hit_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ray_valid) begin
            ist_origin_x <= origin_x;
            ist_origin_y <= origin_y;
            ist_origin_z <= origin_z;
            ist_dir_x    <= dir_x;
            ist_dir_y    <= dir_y;
            ist_dir_z    <= dir_z;
            ist_tmax     <= tmax;
            idx          <= tri_first;
            remaining    <= tri_count;
            hit          <= 1'b0;
            hit_t        <= tmax;
            hit_u        <= '0;
            hit_v        <= '0;
            hit_index    <= '0;
            ray_ready    <= 1'b0;
            busy         <= 1'b1;
            if (tri_count == '0) begin
              state     <= S_DONE;
              hit_valid <= 1'b1;
            end else begin
              state    <= S_FETCH;
              tri_req  <= 1'b1;
              tri_addr <= tri_first;
            end
          end
        end
        S_FETCH: state <= S_WAIT_MEM;
        S_WAIT_MEM: begin
          if (tri_rvalid) begin
            tri_buf   <= tri_rdata;
            ist_valid <= 1'b1;
            state     <= S_ISSUE;
`ifdef IST_DISPATCH_PREFETCH_EN
            pf_pend   <= 1'b0;
`endif
          end
        end
        S_ISSUE: begin
          state <= S_WAIT_IST;
`ifdef IST_DISPATCH_PREFETCH_EN
          // Fetch the next triangle while ist runs; none after the last one.
          if (remaining > REM_ONE) begin
            tri_req  <= 1'b1;
            tri_addr <= idx + IDX_ONE;
            pf_pend  <= 1'b1;
          end
`endif
        end
        S_WAIT_IST: begin
`ifdef IST_DISPATCH_PREFETCH_EN
          if (pf_pend && tri_rvalid && !ist_done) begin
            pf_buf  <= tri_rdata;
            pf_have <= 1'b1;
            pf_pend <= 1'b0;
          end
`endif
          if (ist_done) begin
            if (ist_intersected) begin
              hit       <= 1'b1;
              hit_t     <= ist_t;
              hit_u     <= ist_u;
              hit_v     <= ist_v;
              hit_index <= idx;
              ist_tmax  <= ist_t;
            end
            idx       <= idx + IDX_ONE;
            remaining <= remaining - REM_ONE;
            if (remaining == REM_ONE) begin
              state     <= S_DONE;
              hit_valid <= 1'b1;
            end else begin
`ifdef IST_DISPATCH_PREFETCH_EN
              if (pf_have) begin
                tri_buf   <= pf_buf;
                pf_have   <= 1'b0;
                ist_valid <= 1'b1;
                state     <= S_ISSUE;
              end else if (pf_pend && tri_rvalid) begin
                // Prefetch data lands in the same cycle as ist_done.
                tri_buf   <= tri_rdata;
                pf_pend   <= 1'b0;
                ist_valid <= 1'b1;
                state     <= S_ISSUE;
              end else if (pf_pend) begin
                // Read already outstanding at tri_addr; just wait for it.
                state <= S_WAIT_MEM;
              end else begin
                state    <= S_FETCH;
                tri_req  <= 1'b1;
                tri_addr <= idx + IDX_ONE;
              end
`else
              state    <= S_FETCH;
              tri_req  <= 1'b1;
              tri_addr <= idx + IDX_ONE;
`endif
            end
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          ray_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
